// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module  : cache_pkg
// Brief   : Shared types and defaults for the cache port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      FILL   = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } arb_state_t;

   localparam int DWS_DEFAULT = 16;
   localparam int MAS_DEFAULT = 10;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module  : rr_pick
// Brief   : Combinational round-robin picker; first set request after last.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   idx
);

   int w_cand;

   // Scan from the farthest slot back to the nearest so the nearest hit wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      w_cand = 0;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = (int'(last) + k) % NREQ;
         if (req[w_cand]) begin
            valid = 1'b1;
            idx   = IW'(w_cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
//------------------------------------------------------------------------------
// Module  : cache_arbiter
// Brief   : Round-robin sharing of one cache processor port among NREQ masters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_arbiter
   import cache_pkg::*;
#(
   parameter int DWS  = DWS_DEFAULT,
   parameter int MAS  = MAS_DEFAULT,
   parameter int NREQ = 2,
   parameter int TMO  = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     we,
   input  logic [NREQ*MAS-1:0] addr,
   input  logic [NREQ*DWS-1:0] wdata,
   output logic [NREQ-1:0]     ack,
   output logic [DWS-1:0]      rdata,
   output logic                err,
   output logic [MAS-1:0]      pAddr,
   output logic [DWS-1:0]      pDataOut,
   output logic                readRequest,
   output logic                writeRequest,
   input  logic [DWS-1:0]      pDataIn,
   input  logic                busyClock
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TMO + 1);
   localparam logic [NREQ-1:0] C_ONE = NREQ'(1);
   localparam logic [CW-1:0]   C_TMO = CW'(TMO);

   arb_state_t        r_state;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     r_last;
   logic              r_we;
   logic [MAS-1:0]    r_addr;
   logic [DWS-1:0]    r_wdata;
   logic [CW-1:0]     r_cnt;
   logic [NREQ-1:0]   r_ack;
   logic              r_err;
   logic [DWS-1:0]    r_rdata;

   logic              w_valid;
   logic [IW-1:0]     w_idx;
   logic [CW-1:0]     w_cnt_nx;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req   (req),
      .last  (r_last),
      .valid (w_valid),
      .idx   (w_idx)
   );

   assign w_cnt_nx = (r_cnt == C_TMO) ? r_cnt : r_cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_last  <= IW'(NREQ - 1);
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_idx   <= w_idx;
                  r_last  <= w_idx;
                  r_we    <= we[w_idx];
                  r_addr  <= addr[w_idx*MAS +: MAS];
                  r_wdata <= wdata[w_idx*DWS +: DWS];
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               if (r_we) begin
                  r_ack   <= C_ONE << r_idx;
                  r_state <= DONE;
               end else if (!busyClock) begin
                  r_rdata <= pDataIn;
                  r_ack   <= C_ONE << r_idx;
                  r_state <= DONE;
               end else begin
                  r_cnt   <= '0;
                  r_state <= FILL;
               end
            end
            // Line turns valid a cycle before its data, so capture waits for SETTLE.
            FILL: begin
               if (!busyClock) begin
                  r_state <= SETTLE;
               end else begin
                  r_cnt <= w_cnt_nx;
                  if (w_cnt_nx == C_TMO) begin
                     r_err   <= 1'b1;
                     r_ack   <= C_ONE << r_idx;
                     r_state <= DONE;
                  end
               end
            end
            SETTLE: begin
               r_rdata <= pDataIn;
               r_ack   <= C_ONE << r_idx;
               r_state <= DONE;
            end
            DONE: begin
               r_ack   <= '0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      readRequest  = 1'b0;
      writeRequest = 1'b0;
      pAddr        = '0;
      pDataOut     = '0;
      case (r_state)
         SERVE: begin
            pAddr = r_addr;
            if (r_we) begin
               writeRequest = 1'b1;
               pDataOut     = r_wdata;
            end else begin
               readRequest = 1'b1;
            end
         end
         FILL, SETTLE: begin
            pAddr       = r_addr;
            readRequest = 1'b1;
         end
         default: ;
      endcase
   end

   assign ack   = r_ack;
   assign err   = r_err;
   assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_cache_arbiter
// Brief   : Scoreboard bench for cache_arbiter with a small cache model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_arbiter;

   localparam int DWS  = 16;
   localparam int MAS  = 10;
   localparam int NREQ = 2;
   localparam int TMO  = 15;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ-1:0]     we = '0;
   logic [NREQ*MAS-1:0] addr = '0;
   logic [NREQ*DWS-1:0] wdata = '0;
   logic [NREQ-1:0]     ack;
   logic [DWS-1:0]      rdata;
   logic                err;
   logic [MAS-1:0]      pAddr;
   logic [DWS-1:0]      pDataOut;
   logic                readRequest;
   logic                writeRequest;
   logic [DWS-1:0]      pDataIn = 16'hDEAD;
   logic                busyClock = 1'b0;

   cache_arbiter #(
      .DWS (DWS), .MAS (MAS), .NREQ (NREQ), .TMO (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .ack          (ack),
      .rdata        (rdata),
      .err          (err),
      .pAddr        (pAddr),
      .pDataOut     (pDataOut),
      .readRequest  (readRequest),
      .writeRequest (writeRequest),
      .pDataIn      (pDataIn),
      .busyClock    (busyClock)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_failed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int          idx;
      logic [15:0] rd;
      logic        er;
   } exp_t;

   exp_t sbq[$];
   exp_t e;

   task automatic push(input int idx, input logic [15:0] rd, input logic er);
      exp_t x;
      x.idx = idx;
      x.rd  = rd;
      x.er  = er;
      sbq.push_back(x);
   endtask

   // Cache model: cold reads stay busy miss_len cycles, then show junk for one
   // cycle (line valid, data not yet landed), then the fill value.
   logic [15:0] mem [0:1023];
   logic        vld [0:1023];
   int          mstate = 0;
   int          left = 0;
   int          miss_len = 1;
   bit          stuck = 1'b0;

   function automatic logic [15:0] fill_val(input logic [9:0] a);
      return (a == 10'h3A1) ? 16'h1234 : {6'h2A, a};
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 16'h0000;
         vld[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (writeRequest) begin
         mem[pAddr] = pDataOut;
         vld[pAddr] = 1'b1;
      end
      if (stuck) begin
         busyClock = 1'b1;
         pDataIn   = 16'hDEAD;
      end else if (!readRequest) begin
         mstate    = 0;
         busyClock = 1'b0;
         pDataIn   = 16'hDEAD;
      end else begin
         case (mstate)
            0: begin
               if (vld[pAddr]) begin
                  busyClock = 1'b0;
                  pDataIn   = mem[pAddr];
                  mstate    = 3;
               end else begin
                  busyClock = 1'b1;
                  left      = miss_len - 1;
                  mstate    = 1;
               end
            end
            1: begin
               if (left > 0) begin
                  busyClock = 1'b1;
                  left--;
               end else begin
                  busyClock  = 1'b0;
                  pDataIn    = 16'hDEAD;
                  mem[pAddr] = fill_val(pAddr);
                  vld[pAddr] = 1'b1;
                  mstate     = 2;
               end
            end
            default: begin
               busyClock = 1'b0;
               pDataIn   = mem[pAddr];
            end
         endcase
      end
   end

   int          wr_cnt = 0;
   logic [9:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;

   always @(negedge clk) begin
      chk("ack_onehot0", 32'($onehot0(ack)), 1);
      if (writeRequest) begin
         wr_cnt++;
         wr_addr = pAddr;
         wr_data = pDataOut;
      end
      if (ack != '0) begin
         if (sbq.size() == 0) begin
            chk("unexpected_ack", ack, 0);
         end else begin
            e = sbq.pop_front();
            chk("ack_idx", ack, 32'(1) << e.idx);
            chk("rdata", rdata, e.rd);
            chk("err", err, e.er);
         end
      end else begin
         chk("err_without_ack", err, 0);
      end
   end

   task automatic start_req(input int idx, input bit w, input logic [9:0] a, input logic [15:0] d);
      @(negedge clk);
      we[idx]             = w;
      addr[idx*MAS +: MAS] = a;
      wdata[idx*DWS +: DWS] = d;
      req[idx]            = 1'b1;
   endtask

   // Counts negedges from the call; lat is the sample index where ack[idx] must appear.
   task automatic wait_ack(input int idx, input int lat, input bit is_wr,
                           input logic [9:0] ea, input logic [15:0] ed, input bit scr);
      int c;
      bit seen;
      int wb;
      c    = 0;
      seen = 1'b0;
      wb   = wr_cnt;
      while (!seen && c < 100) begin
         @(negedge clk);
         c++;
         if (scr && c == 1) begin
            addr[idx*MAS +: MAS]  = ~addr[idx*MAS +: MAS];
            wdata[idx*DWS +: DWS] = ~wdata[idx*DWS +: DWS];
         end
         if (ack[idx]) begin
            seen = 1'b1;
            chk("latency", c, lat);
            chk("no_cache_req_at_ack", {readRequest, writeRequest}, 0);
            if (is_wr) begin
               chk("wr_pulses", wr_cnt - wb, 1);
               chk("wr_addr", wr_addr, ea);
               chk("wr_data", wr_data, ed);
            end
            req[idx] = 1'b0;
         end
      end
      chk("ack_seen", seen, 1);
   endtask

   initial begin
      int n;
      logic [NREQ-1:0] pend;
      int m_last;

      // Reset held with both masters requesting
      we    = 2'b11;
      addr  = {10'h006, 10'h005};
      wdata = {16'h0BAD, 16'hBEEF};
      req   = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ack", ack, 0);
         chk("rst_rdreq", readRequest, 0);
         chk("rst_wrreq", writeRequest, 0);
         chk("rst_paddr", pAddr, 0);
      end
      chk("rst_rdata", rdata, 0);
      push(0, 16'h0000, 1'b0);
      push(1, 16'h0000, 1'b0);
      reset = 1'b1;
      wait_ack(0, 2, 1'b1, 10'h005, 16'hBEEF, 1'b1);
      wait_ack(1, 3, 1'b1, 10'h006, 16'h0BAD, 1'b0);

      // Read hit of the line just written
      start_req(0, 1'b0, 10'h005, 16'h0000);
      push(0, 16'hBEEF, 1'b0);
      wait_ack(0, 2, 1'b0, 10'h000, 16'h0000, 1'b1);

      // Cold read: one busy cycle, junk cycle, then fill data
      miss_len = 1;
      start_req(1, 1'b0, 10'h3A1, 16'h0000);
      push(1, 16'h1234, 1'b0);
      wait_ack(1, 4, 1'b0, 10'h000, 16'h0000, 1'b1);

      // Both masters hammering: grants rotate starting after the last winner (1)
      m_last = 1;
      for (int i = 0; i < 4; i++) begin
         m_last = (m_last + 1) % NREQ;
         push(m_last, (m_last == 0) ? 16'hBEEF : 16'h1234, 1'b0);
      end
      @(negedge clk);
      we   = 2'b00;
      addr = {10'h3A1, 10'h005};
      req  = 2'b11;
      n    = 0;
      pend = '0;
      for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
         @(negedge clk);
         if (pend != '0) begin
            req  = req | pend;
            pend = '0;
         end
         if (ack != '0) begin
            n++;
            req = req & ~ack;
            if (n < 3) pend = ack;
         end
      end
      chk("rotation_acks", n, 4);
      req = '0;

      // Cache never finishes: timeout abort, rdata keeps last read value
      stuck = 1'b1;
      start_req(0, 1'b0, 10'h010, 16'h0000);
      push(0, 16'h1234, 1'b1);
      wait_ack(0, TMO + 2, 1'b0, 10'h000, 16'h0000, 1'b0);
      stuck = 1'b0;
      start_req(1, 1'b0, 10'h005, 16'h0000);
      push(1, 16'hBEEF, 1'b0);
      wait_ack(1, 2, 1'b0, 10'h000, 16'h0000, 1'b0);

      // Reset during FILL drops the access; the held request is served afterwards
      miss_len = 3;
      start_req(0, 1'b0, 10'h020, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      chk("in_fill_rdreq", readRequest, 1);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("midrst_ack", ack, 0);
         chk("midrst_rdreq", readRequest, 0);
      end
      push(0, fill_val(10'h020), 1'b0);
      reset = 1'b1;
      wait_ack(0, 6, 1'b0, 10'h000, 16'h0000, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule

`default_nettype wire
